// File: rtl/fetch_unit.sv
// Fetch unit: sequences instruction fetch across the P1..P5 phases issued by the
// control unit, owns the program counter and retired-instruction counter, and
// parks in HALTED on an HLT word until a resume pulse arrives.
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic        op_branch,
  input  logic [15:0] branch_address,
  input  logic        resume,
  output logic [15:0] imem_addr,
  output logic        imem_ren,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction_wire,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [2:0] PhFetch  = 3'b001;
  localparam logic [2:0] PhLoad   = 3'b010;
  localparam logic [2:0] PhUpdate = 3'b101;

  typedef enum logic [0:0] {StRun, StHalted} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] count_q, count_d;
  logic        rdata_is_hlt;

  // HLT: top two bits set and the [7:4] nibble all ones.
  assign rdata_is_hlt = (imem_rdata[15:14] == 2'b11) && (imem_rdata[7:4] == 4'hF);

  assign pc_plus1         = pc_q + 16'h0001;
  assign pc               = pc_q;
  assign imem_addr        = pc_q;
  assign instruction_wire = instr_q;
  assign instr_count      = count_q;

  // FSM state register; reset wins over every other event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm_q <= StRun;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state: halt on an HLT word loaded at P2, leave on resume.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StRun:    if (state == PhLoad && rdata_is_hlt) fsm_d = StHalted;
      StHalted: if (resume) fsm_d = StRun;
      default:  fsm_d = StRun;
    endcase
  end

  // FSM outputs; read enable is forced low while reset is held.
  always_comb begin
    halted   = (fsm_q == StHalted);
    imem_ren = reset && (fsm_q == StRun) && (state == PhFetch);
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= 16'h0000;
      instr_q <= 16'h0000;
      count_q <= 16'h0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Datapath next state: phase-driven in RUN, resume-driven in HALTED.
  // Any phase code other than P2/P5 leaves every register untouched.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    if (fsm_q == StRun) begin
      if (state == PhLoad) begin
        instr_d = imem_rdata;
      end
      if (state == PhUpdate) begin
        pc_d    = op_branch ? branch_address : pc_plus1;
        count_d = count_q + 16'h0001;
      end
    end else if (resume) begin
      // The HLT itself retires on resume; a coincident P5 is ignored.
      pc_d    = pc_plus1;
      count_d = count_q + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected register values and
// expected fetch addresses into queues; a negedge monitor pops and compares.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  state = 3'b000;
  logic        op_branch = 1'b0;
  logic [15:0] branch_address = 16'h0000;
  logic        resume = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_ren;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instruction_wire;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [15:0] fetch_q[$];
  logic [15:0] mem [logic [15:0]];

  fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .state            (state),
    .op_branch        (op_branch),
    .branch_address   (branch_address),
    .resume           (resume),
    .imem_addr        (imem_addr),
    .imem_ren         (imem_ren),
    .imem_rdata       (imem_rdata),
    .instruction_wire (instruction_wire),
    .pc               (pc),
    .pc_plus1         (pc_plus1),
    .halted           (halted),
    .instr_count      (instr_count)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  // Instruction memory: one-cycle read latency.
  always @(posedge clock) begin
    if (imem_ren) imem_rdata <= mem_rd(imem_addr);
  end

  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      0: return pc;
      1: return instruction_wire;
      2: return instr_count;
      3: return {15'b0, halted};
      4: return pc_plus1;
      5: return {15'b0, imem_ren};
      default: return imem_addr;
    endcase
  endfunction

  task automatic chk(input string n, input int sel, input logic [15:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  // Monitor: every cycle, read enable must match whether a fetch was issued,
  // fetched addresses must match, and queued register checks are drained.
  always @(negedge clock) begin
    logic        exp_ren;
    logic [15:0] a;
    chk_t        c;
    exp_ren = (fetch_q.size() != 0);
    checks++;
    if (imem_ren !== exp_ren) begin
      errors++;
      $display("FAIL imem_ren t=%0t actual=%b required=%b", $time, imem_ren, exp_ren);
    end
    if (exp_ren) begin
      a = fetch_q.pop_front();
      checks++;
      if (imem_addr !== a) begin
        errors++;
        $display("FAIL imem_addr t=%0t actual=%h required=%h", $time, imem_addr, a);
      end
    end
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      checks++;
      if (dut_val(c.sel) !== c.exp) begin
        errors++;
        $display("FAIL %s t=%0t actual=%h required=%h", c.name, $time, dut_val(c.sel), c.exp);
      end
    end
  end

  task automatic cyc(input logic [2:0] st);
    state = st;
    @(posedge clock);
    #1;
  endtask

  // One full P1..P5 instruction with expected fetch address and results.
  task automatic run_instr(input logic [15:0] addr, input logic br, input logic [15:0] ba,
                           input logic [15:0] exp_iw, input logic [15:0] exp_pc,
                           input logic [15:0] exp_cnt);
    fetch_q.push_back(addr);
    cyc(3'b001);
    cyc(3'b010);
    chk("instr_after_p2", 1, exp_iw);
    cyc(3'b011);
    cyc(3'b100);
    op_branch      = br;
    branch_address = ba;
    cyc(3'b101);
    op_branch = 1'b0;
    chk("pc_after_p5", 0, exp_pc);
    chk("count_after_p5", 2, exp_cnt);
  endtask

  initial begin
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h5678;
    mem[16'h0003] = 16'hC0F0;
    mem[16'h0004] = 16'h2222;
    mem[16'h0010] = 16'hABCD;
    mem[16'h0040] = 16'h4040;

    // Reset with P1 on the bus: no fetch, all registers cleared.
    cyc(3'b001);
    cyc(3'b001);
    chk("rst_pc", 0, 16'h0000);
    chk("rst_instr", 1, 16'h0000);
    chk("rst_count", 2, 16'h0000);
    chk("rst_halted", 3, 16'h0000);
    chk("rst_ren", 5, 16'h0000);
    reset = 1'b1;
    cyc(3'b000);

    // Sequential fetch.
    run_instr(16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h0001, 16'h0001);
    run_instr(16'h0001, 1'b0, 16'h0000, 16'h5678, 16'h0002, 16'h0002);

    // Branch taken then not taken.
    run_instr(16'h0002, 1'b1, 16'h0040, 16'h0000, 16'h0040, 16'h0003);
    run_instr(16'h0040, 1'b0, 16'h0000, 16'h4040, 16'h0041, 16'h0004);

    // Resume in RUN is ignored.
    resume = 1'b1;
    cyc(3'b000);
    resume = 1'b0;
    chk("resume_run_pc", 0, 16'h0041);
    chk("resume_run_count", 2, 16'h0004);
    chk("resume_run_halted", 3, 16'h0000);

    // Idle and non-updating phase codes.
    for (int i = 0; i < 3; i++) cyc(3'b110);
    for (int i = 0; i < 3; i++) cyc(3'b111);
    cyc(3'b011);
    cyc(3'b100);
    chk("idle_pc", 0, 16'h0041);
    chk("idle_instr", 1, 16'h4040);
    chk("idle_count", 2, 16'h0004);

    // Wrap-around of pc.
    run_instr(16'h0041, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0005);
    chk("pc_plus1_at_ffff", 4, 16'h0000);
    run_instr(16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0006);
    chk("pc_plus1_wrap", 4, 16'h0001);

    // Halt at address 3.
    run_instr(16'h0000, 1'b1, 16'h0003, 16'h1234, 16'h0003, 16'h0007);
    fetch_q.push_back(16'h0003);
    cyc(3'b001);
    cyc(3'b010);
    chk("halt_set", 3, 16'h0001);
    chk("halt_instr", 1, 16'hC0F0);
    op_branch      = 1'b1;
    branch_address = 16'h00AA;
    cyc(3'b011);
    cyc(3'b100);
    cyc(3'b101);
    chk("halt_p5_pc", 0, 16'h0003);
    chk("halt_p5_count", 2, 16'h0007);
    for (int i = 0; i < 20; i++) begin
      cyc(3'((i % 5) + 1));
      chk("halt_hold_pc", 0, 16'h0003);
      chk("halt_hold_flag", 3, 16'h0001);
    end
    chk("halt_hold_instr", 1, 16'hC0F0);
    chk("halt_hold_count", 2, 16'h0007);

    // Resume coinciding with P5: single increment, branch ignored.
    branch_address = 16'h0077;
    resume         = 1'b1;
    cyc(3'b101);
    resume    = 1'b0;
    op_branch = 1'b0;
    chk("resume_pc", 0, 16'h0004);
    chk("resume_count", 2, 16'h0008);
    chk("resume_halted", 3, 16'h0000);
    run_instr(16'h0004, 1'b0, 16'h0000, 16'h2222, 16'h0005, 16'h0009);

    // Mid-instruction reset at P3 with pc=0x0010.
    run_instr(16'h0005, 1'b1, 16'h0010, 16'h0000, 16'h0010, 16'h000A);
    fetch_q.push_back(16'h0010);
    cyc(3'b001);
    cyc(3'b010);
    chk("pre_rst_instr", 1, 16'hABCD);
    reset = 1'b0;
    cyc(3'b011);
    chk("midrst_pc", 0, 16'h0000);
    chk("midrst_instr", 1, 16'h0000);
    chk("midrst_count", 2, 16'h0000);
    chk("midrst_halted", 3, 16'h0000);
    reset = 1'b1;
    cyc(3'b000);
    run_instr(16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h0001, 16'h0001);

    state = 3'b000;
    @(negedge clock);
    #1;
    checks++;
    if (fetch_q.size() != 0) begin
      errors++;
      $display("FAIL fetch_drain actual=%0d required=0", fetch_q.size());
    end
    checks++;
    if (chk_q.size() != 0) begin
      errors++;
      $display("FAIL check_drain actual=%0d required=0", chk_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
